coin_accumulator: RTL and testbench

//  Upstream stage of Bill_Calculator: accepts coins, holds the running credit, drives cash_in/set_drink.
//  On vend request, samples calculator cash_low/cash_bal and issues a one-cycle dispense and change pulse.

---
 rtl/coin_accumulator_pkg.sv | 26 ++
 rtl/coin_accumulator_coin_decoder.sv | 27 ++
 rtl/coin_accumulator.sv | 179 +++++++++++++++++
 tb/tb_coin_accumulator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_accumulator_pkg.sv
// Shared definitions for the vending front end: FSM states, coin codes and
// drink encoding (0 = coffee, 1 = tea, same as set_drink).
package coin_accumulator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_CHECK   = 3'd2,
      ST_VEND    = 3'd3,
      ST_REFUND  = 3'd4
   } state_t;

   localparam logic [1:0] COIN_CODE_0   = 2'b00;
   localparam logic [1:0] COIN_CODE_1   = 2'b01;
   localparam logic [1:0] COIN_CODE_2   = 2'b10;
   localparam logic [1:0] COIN_CODE_BAD = 2'b11;

   localparam logic DRINK_COFFEE = 1'b0;
   localparam logic DRINK_TEA    = 1'b1;

   // States in which the accumulator refuses new coins and reports busy.
   function automatic logic is_busy_state(input state_t s);
      return (s == ST_CHECK) || (s == ST_VEND) || (s == ST_REFUND);
   endfunction

endpackage

// File: rtl/coin_accumulator_coin_decoder.sv
// Combinational coin decoder: maps the 2-bit coin code to its credit value
// and flags the unused code as invalid.
module coin_decoder
   import coin_accumulator_pkg::*;
#(
   parameter int unsigned COIN_V0 = 5,
   parameter int unsigned COIN_V1 = 10,
   parameter int unsigned COIN_V2 = 20
) (
   input  logic [1:0] i_coin_type,
   output logic [6:0] o_value,
   output logic       o_invalid
);

   // Value lookup; the invalid code yields value 0 and raises the flag.
   always_comb begin
      o_value   = 7'd0;
      o_invalid = 1'b0;
      case (i_coin_type)
         COIN_CODE_0: o_value = 7'(COIN_V0);
         COIN_CODE_1: o_value = 7'(COIN_V1);
         COIN_CODE_2: o_value = 7'(COIN_V2);
         default:     o_invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: collects coins into a credit register feeding the bill
// calculator, then on a vend request samples the calculator verdict and
// emits one-cycle dispense/change pulses. Cancel refunds the whole credit.
module coin_accumulator
   import coin_accumulator_pkg::*;
#(
   parameter int unsigned MAX_CASH = 100,
   parameter int unsigned COIN_V0  = 5,
   parameter int unsigned COIN_V1  = 10,
   parameter int unsigned COIN_V2  = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       drink_sel,
   input  logic       vend_req,
   input  logic       cancel,
   input  logic       cash_low,
   input  logic [6:0] cash_bal,
   output logic [6:0] cash_in,
   output logic       set_drink,
   output logic       coin_reject,
   output logic       insufficient,
   output logic       dispense_cof,
   output logic       dispense_tea,
   output logic       change_valid,
   output logic [6:0] change_out,
   output logic       busy
);

   localparam logic [7:0] MAX_CASH_8 = 8'(MAX_CASH);

   state_t     r_state, w_state_next;
   logic [6:0] r_credit, w_credit_next;
   logic       r_sel, w_sel_next;
   logic [6:0] r_bal, w_bal_next;
   logic       r_coin_reject, w_coin_reject_next;
   logic       r_insufficient, w_insufficient_next;
   logic       r_disp_cof, w_disp_cof_next;
   logic       r_disp_tea, w_disp_tea_next;
   logic       r_change_valid, w_change_valid_next;
   logic [6:0] r_change_out, w_change_out_next;
   logic       r_busy;
   logic       w_busy_next;

   logic [6:0] w_coin_value;
   logic       w_coin_invalid;
   logic [7:0] w_sum;

   coin_decoder #(
      .COIN_V0 (COIN_V0),
      .COIN_V1 (COIN_V1),
      .COIN_V2 (COIN_V2)
   ) u_coin_decoder (
      .i_coin_type (coin_type),
      .o_value     (w_coin_value),
      .o_invalid   (w_coin_invalid)
   );

   // One bit wider than the credit so an over-ceiling sum cannot wrap.
   assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_value};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic plus next values for the data and pulse registers.
   always_comb begin
      w_state_next        = r_state;
      w_credit_next       = r_credit;
      w_sel_next          = r_sel;
      w_bal_next          = r_bal;
      w_coin_reject_next  = 1'b0;
      w_insufficient_next = 1'b0;
      w_disp_cof_next     = 1'b0;
      w_disp_tea_next     = 1'b0;
      w_change_valid_next = 1'b0;
      w_change_out_next   = 7'd0;
      case (r_state)
         ST_IDLE: begin
            if (coin_valid) begin
               if (w_coin_invalid) begin
                  w_coin_reject_next = 1'b1;
               end else begin
                  w_credit_next = w_coin_value;
                  w_state_next  = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (cancel) begin
               w_coin_reject_next = coin_valid;
               w_state_next       = ST_REFUND;
            end else if (vend_req) begin
               w_coin_reject_next = coin_valid;
               w_sel_next         = drink_sel;
               w_state_next       = ST_CHECK;
            end else if (coin_valid) begin
               if (w_coin_invalid || (w_sum > MAX_CASH_8)) w_coin_reject_next = 1'b1;
               else                                       w_credit_next      = w_sum[6:0];
            end
         end
         ST_CHECK: begin
            // Calculator inputs have settled on the credit and latched selection.
            w_coin_reject_next = coin_valid;
            if (cash_low) begin
               w_insufficient_next = 1'b1;
               w_state_next        = ST_COLLECT;
            end else begin
               w_bal_next   = cash_bal;
               w_state_next = ST_VEND;
            end
         end
         ST_VEND: begin
            w_coin_reject_next  = coin_valid;
            w_disp_cof_next     = (r_sel == DRINK_COFFEE);
            w_disp_tea_next     = (r_sel == DRINK_TEA);
            w_change_valid_next = 1'b1;
            w_change_out_next   = r_bal;
            w_credit_next       = 7'd0;
            w_state_next        = ST_IDLE;
         end
         ST_REFUND: begin
            w_coin_reject_next  = coin_valid;
            w_change_valid_next = 1'b1;
            w_change_out_next   = r_credit;
            w_credit_next       = 7'd0;
            w_state_next        = ST_IDLE;
         end
         default: begin
            w_credit_next = 7'd0;
            w_state_next  = ST_IDLE;
         end
      endcase
   end

   assign w_busy_next = is_busy_state(w_state_next);

   // Data registers and registered outputs; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit       <= 7'd0;
         r_sel          <= DRINK_COFFEE;
         r_bal          <= 7'd0;
         r_coin_reject  <= 1'b0;
         r_insufficient <= 1'b0;
         r_disp_cof     <= 1'b0;
         r_disp_tea     <= 1'b0;
         r_change_valid <= 1'b0;
         r_change_out   <= 7'd0;
         r_busy         <= 1'b0;
      end else begin
         r_credit       <= w_credit_next;
         r_sel          <= w_sel_next;
         r_bal          <= w_bal_next;
         r_coin_reject  <= w_coin_reject_next;
         r_insufficient <= w_insufficient_next;
         r_disp_cof     <= w_disp_cof_next;
         r_disp_tea     <= w_disp_tea_next;
         r_change_valid <= w_change_valid_next;
         r_change_out   <= w_change_out_next;
         r_busy         <= w_busy_next;
      end
   end

   assign cash_in      = r_credit;
   assign set_drink    = r_sel;
   assign coin_reject  = r_coin_reject;
   assign insufficient = r_insufficient;
   assign dispense_cof = r_disp_cof;
   assign dispense_tea = r_disp_tea;
   assign change_valid = r_change_valid;
   assign change_out   = r_change_out;
   assign busy         = r_busy;

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator with a simple bill-calculator stand-in
// (coffee 50, tea 35) and a transaction-level credit model.
module tb_coin_accumulator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_type = 2'b00;
   logic       drink_sel = 1'b0;
   logic       vend_req = 1'b0;
   logic       cancel = 1'b0;
   logic       cash_low;
   logic [6:0] cash_bal;
   logic [6:0] cash_in;
   logic       set_drink, coin_reject, insufficient;
   logic       dispense_cof, dispense_tea, change_valid, busy;
   logic [6:0] change_out;
   logic [6:0] price;

   int tests_run = 0;
   int tests_failed = 0;

   // Model: credit held and whether a purchase session is open.
   int m_credit = 0;
   bit m_active = 1'b0;

   always #5 clk = ~clk;

   // Bill calculator stand-in: refuses when credit is below the drink price.
   assign price    = set_drink ? 7'd35 : 7'd50;
   assign cash_low = (cash_in < price);
   assign cash_bal = cash_low ? 7'd0 : 7'(cash_in - price);

   coin_accumulator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .drink_sel    (drink_sel),
      .vend_req     (vend_req),
      .cancel       (cancel),
      .cash_low     (cash_low),
      .cash_bal     (cash_bal),
      .cash_in      (cash_in),
      .set_drink    (set_drink),
      .coin_reject  (coin_reject),
      .insufficient (insufficient),
      .dispense_cof (dispense_cof),
      .dispense_tea (dispense_tea),
      .change_valid (change_valid),
      .change_out   (change_out),
      .busy         (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drive one cycle of strobes; returns 1 time unit after the sampling edge.
   task automatic step(input logic cv, input logic [1:0] ct, input logic vr,
                       input logic ds, input logic cn);
      @(negedge clk);
      coin_valid = cv; coin_type = ct; vend_req = vr; drink_sel = ds; cancel = cn;
      @(posedge clk);
      #1;
      coin_valid = 1'b0; vend_req = 1'b0; cancel = 1'b0;
   endtask

   task automatic op_coin(input logic [1:0] ct);
      int  val;
      bit  rej;
      logic [8:0] obs, exp_v;
      val = (ct == 2'b00) ? 5 : (ct == 2'b01) ? 10 : (ct == 2'b10) ? 20 : -1;
      rej = 1'b0;
      if (val < 0)                  rej = 1'b1;
      else if (!m_active)           begin m_credit = val; m_active = 1'b1; end
      else if (m_credit + val > 100) rej = 1'b1;
      else                          m_credit = m_credit + val;
      step(1'b1, ct, 1'b0, drink_sel, 1'b0);
      obs   = {coin_reject, busy, cash_in};
      exp_v = {rej, 1'b0, 7'(m_credit)};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL coin type=%0d {reject,busy,credit}: got %h expected %h", ct, obs, exp_v);
      end else $display("[TB] coin type=%0d reject=%0d credit=%0d", ct, rej, m_credit);
   endtask

   task automatic op_vend(input logic sel, input bit coin_same, input bit coin_check);
      int price_m, chg;
      logic [9:0] obs, exp_v;
      logic [13:0] obs2, exp2;
      price_m = sel ? 35 : 50;
      if (!m_active) begin
         step(1'b0, 2'b00, 1'b1, sel, 1'b0);
         step(1'b0, 2'b00, 1'b0, sel, 1'b0);
         step(1'b0, 2'b00, 1'b0, sel, 1'b0);
         obs   = {busy, insufficient, dispense_cof, dispense_tea, change_valid, 1'b0, cash_in[3:0]};
         exp_v = 10'd0;
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL vend_idle_ignored: got %h expected %h", obs, exp_v);
         end else $display("[TB] vend in idle ignored");
         return;
      end
      step(coin_same, 2'b10, 1'b1, sel, 1'b0);
      obs   = {busy, coin_reject, set_drink, cash_in};
      exp_v = {1'b1, coin_same, sel, 7'(m_credit)};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL vend_req {busy,reject,sel,credit}: got %h expected %h", obs, exp_v);
      end
      step(coin_check, 2'b01, 1'b0, sel, 1'b0);
      if (m_credit < price_m) begin
         obs   = {insufficient, busy, coin_reject, dispense_cof, dispense_tea, change_valid, 4'd0};
         exp_v = {1'b1, 1'b0, coin_check, 3'b000, 4'd0};
         obs2  = {7'd0, cash_in};
         exp2  = {7'd0, 7'(m_credit)};
         tests_run++;
         if (obs !== exp_v || obs2 !== exp2) begin
            tests_failed++;
            $display("FAIL vend_insufficient: got %h/%h expected %h/%h", obs, obs2, exp_v, exp2);
         end else $display("[TB] vend sel=%0d insufficient credit=%0d", sel, m_credit);
         return;
      end
      obs   = {insufficient, busy, coin_reject, dispense_cof, dispense_tea, change_valid, 4'd0};
      exp_v = {1'b0, 1'b1, coin_check, 3'b000, 4'd0};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL vend_n_plus_1 early pulse: got %h expected %h", obs, exp_v);
      end
      chg = m_credit - price_m;
      step(1'b0, 2'b00, 1'b0, sel, 1'b0);
      obs2 = {dispense_cof, dispense_tea, change_valid, busy, change_out, cash_in[2:0]};
      exp2 = {sel == 1'b0, sel == 1'b1, 1'b1, 1'b0, 7'(chg), 3'd0};
      tests_run++;
      if (obs2 !== exp2 || cash_in !== 7'd0) begin
         tests_failed++;
         $display("FAIL vend_n_plus_2 {cof,tea,cv,busy,change}: got %h credit=%0d expected %h credit=0",
                  obs2, cash_in, exp2);
      end else $display("[TB] vend sel=%0d dispensed change=%0d", sel, chg);
      m_credit = 0;
      m_active = 1'b0;
   endtask

   task automatic op_cancel();
      logic [15:0] obs, exp_v;
      if (!m_active) begin
         step(1'b0, 2'b00, 1'b0, drink_sel, 1'b1);
         obs   = {busy, change_valid, change_out, cash_in};
         exp_v = 16'd0;
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL cancel_idle_ignored: got %h expected %h", obs, exp_v);
         end else $display("[TB] cancel in idle ignored");
         return;
      end
      step(1'b0, 2'b00, 1'b0, drink_sel, 1'b1);
      obs   = {busy, change_valid, 7'd0, cash_in};
      exp_v = {1'b1, 1'b0, 7'd0, 7'(m_credit)};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL cancel_n {busy,cv,credit}: got %h expected %h", obs, exp_v);
      end
      step(1'b0, 2'b00, 1'b0, drink_sel, 1'b0);
      obs   = {busy, change_valid, change_out, cash_in};
      exp_v = {1'b0, 1'b1, 7'(m_credit), 7'd0};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL cancel_refund {busy,cv,change,credit}: got %h expected %h", obs, exp_v);
      end else $display("[TB] cancel refund=%0d", m_credit);
      m_credit = 0;
      m_active = 1'b0;
   endtask

   task automatic test_reset();
      logic [28:0] obs;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      obs = {cash_in, set_drink, coin_reject, insufficient, dispense_cof, dispense_tea,
             change_valid, change_out, busy, 7'd0};
      tests_run++;
      if (obs !== 29'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected 0", obs);
      end else $display("[TB] reset outputs all zero");
      @(negedge clk);
      rst_n = 1'b1;
      m_credit = 0;
      m_active = 1'b0;
   endtask

   task automatic test_exact_coffee();
      op_coin(2'b10); op_coin(2'b10); op_coin(2'b01);
      op_vend(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_tea_change();
      op_coin(2'b10); op_coin(2'b10);
      op_vend(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_insufficient();
      op_coin(2'b10);
      op_vend(1'b0, 1'b0, 1'b0);
      op_coin(2'b10); op_coin(2'b01);
      op_vend(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_ceiling();
      for (int i = 0; i < 5; i++) op_coin(2'b10);
      op_coin(2'b00);
      op_cancel();
   endtask

   task automatic test_reject_cases();
      op_coin(2'b11);
      op_coin(2'b01);
      op_vend(1'b0, 1'b1, 1'b0);
      op_coin(2'b11);
      op_coin(2'b10); op_coin(2'b10);
      op_vend(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_check();
      logic [28:0] obs;
      logic [10:0] obs2;
      op_coin(2'b10); op_coin(2'b01); op_coin(2'b00);
      step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      obs = {cash_in, set_drink, coin_reject, insufficient, dispense_cof, dispense_tea,
             change_valid, change_out, busy, 7'd0};
      tests_run++;
      if (obs !== 29'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_check outputs: got %h expected 0", obs);
      end else $display("[TB] reset mid-check cleared outputs");
      m_credit = 0;
      m_active = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         obs2 = {dispense_cof, dispense_tea, change_valid, busy, cash_in};
         tests_run++;
         if (obs2 !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_check after release cycle %0d: got %h expected 0", i, obs2);
         end
      end
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      op_coin(2'($urandom_range(0, 3)));
         else if (r < 9) op_vend(1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                                 bit'($urandom_range(0, 1)));
         else            op_cancel();
      end
      if (m_active) op_cancel();
   endtask

   initial begin
      test_reset();
      test_exact_coffee();
      test_tea_change();
      test_insufficient();
      test_ceiling();
      test_reject_cases();
      test_reset_mid_check();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
